// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order word requests to instruction
// memory and buffers returned words with their PCs until decode pops them.
// A redirect flushes the queue. Responses that are still in flight for flushed
// requests are counted in drop_cnt and discarded when they arrive.
module instr_fetch_queue #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DATA_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);
  localparam logic [DATA_W-1:0] PC_STEP    = DATA_W'(4);
  localparam logic [SUM_W-1:0]  DEPTH_SUM  = SUM_W'(DEPTH);

  // Queue storage: PC is written at request accept, the word at response
  logic [DATA_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;

  // head: oldest entry, tail: next slot to allocate, fill: oldest unfilled
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  fill_q;

  logic [CNT_W-1:0]  alloc_cnt;
  logic [CNT_W-1:0]  unfilled_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  logic [DATA_W-1:0] fetch_pc_q;
  // Holds off requests during the first cycle after reset
  logic              run_q;

  logic              head_filled_c;
  logic              accept_c;
  logic              pop_c;
  logic              fill_c;
  logic              discard_c;
  logic [SUM_W-1:0]  outstanding_c;
  logic [SUM_W-1:0]  pending_c;
  logic [CNT_W-1:0]  drop_next_c;

  // Handshake decode, output muxing and post-redirect drop count
  always_comb begin
    head_filled_c  = filled_q[head_q];
    outstanding_c  = SUM_W'(alloc_cnt) + SUM_W'(drop_cnt);
    imem_req_valid = run_q & ~redirect_valid & (outstanding_c < DEPTH_SUM);
    imem_req_addr  = fetch_pc_q;
    accept_c       = imem_req_valid & imem_req_ready;
    out_valid      = head_filled_c & ~redirect_valid;
    pop_c          = out_valid & out_ready;
    out_pc         = head_filled_c ? pc_q[head_q]    : '0;
    out_instr      = head_filled_c ? instr_q[head_q] : '0;
    discard_c      = imem_rsp_valid & (drop_cnt != '0);
    fill_c         = imem_rsp_valid & (drop_cnt == '0) & (unfilled_cnt != '0);
    // Every request still owed a response becomes a drop; one arriving now is
    // consumed by the redirect cycle itself.
    pending_c      = SUM_W'(drop_cnt) + SUM_W'(unfilled_cnt);
    if (imem_rsp_valid && (pending_c != '0)) begin
      pending_c = pending_c - SUM_W'(1);
    end
    drop_next_c    = CNT_W'(pending_c);
  end

  // Queue, pointers, counters and fetch PC; redirect overrides everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q     <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      fill_q       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
      drop_cnt     <= '0;
      fetch_pc_q   <= RESET_PC & ALIGN_MASK;
      run_q        <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        filled_q     <= '0;
        head_q       <= '0;
        tail_q       <= '0;
        fill_q       <= '0;
        alloc_cnt    <= '0;
        unfilled_cnt <= '0;
        drop_cnt     <= drop_next_c;
        fetch_pc_q   <= redirect_pc & ALIGN_MASK;
      end else begin
        if (accept_c) begin
          pc_q[tail_q]     <= fetch_pc_q;
          filled_q[tail_q] <= 1'b0;
          tail_q           <= PTR_W'(tail_q + PTR_W'(1));
          fetch_pc_q       <= fetch_pc_q + PC_STEP;
        end
        if (fill_c) begin
          instr_q[fill_q]  <= imem_rsp_data;
          filled_q[fill_q] <= 1'b1;
          fill_q           <= PTR_W'(fill_q + PTR_W'(1));
        end
        if (pop_c) begin
          filled_q[head_q] <= 1'b0;
          head_q           <= PTR_W'(head_q + PTR_W'(1));
        end
        if (discard_c) begin
          drop_cnt <= drop_cnt - CNT_W'(1);
        end
        alloc_cnt    <= alloc_cnt + CNT_W'(accept_c) - CNT_W'(pop_c);
        unfilled_cnt <= unfilled_cnt + CNT_W'(accept_c) - CNT_W'(fill_c);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory model with gated accept budget and
// response hold, a scoreboard of expected {pc, instr} pops and directed tests.
module tb_instr_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  // Second instance with a reset PC just below the wrap point
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] pend [$];
  logic [31:0] acc_log [64];
  int          acc_cnt;
  int          budget;
  logic        hold;
  logic        arm;
  int          mon_cyc = 0;
  int          first_acc;
  int          first_out;
  int          last_out;

  always #5 clock = ~clock;

  instr_fetch_queue #(.DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  instr_fetch_queue #(.DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .redirect_valid(w_redirect_valid),
    .redirect_pc(w_redirect_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  // Instruction image: word at address a is (a << 8) | 0x13, so 0x0 -> 0x00000013
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  assign imem_req_ready = (acc_cnt < budget);

  // In-order memory: logs accepts, answers one per cycle unless held
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend.delete();
      acc_cnt        <= 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        pend.push_back(imem_req_addr);
        acc_log[acc_cnt[5:0]] <= imem_req_addr;
        acc_cnt <= acc_cnt + 1;
      end
      if (!hold && pend.size() != 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= word(pend.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over an instruction
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clock);
      mon_cyc++;
      if (!reset) begin
        chk("cnt_bound", 32'((dut.alloc_cnt <= 3'd4) && (dut.drop_cnt <= 3'd4)), 32'd1);
        if (arm && first_acc < 0 && imem_req_valid && imem_req_ready) first_acc = mon_cyc;
        if (out_valid && out_ready) begin
          if (arm) begin
            if (first_out < 0) first_out = mon_cyc;
            last_out = mon_cyc;
          end
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got pc %h, required no pop", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", out_pc, e);
            chk("pop_instr", out_instr, word(e));
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    budget = 0;
    hold = 1'b0;
    arm = 1'b0;
    first_acc = -1;
    first_out = -1;
    last_out = -1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    w_req_ready = 1'b1;
    w_rsp_valid = 1'b0;
    w_rsp_data = 32'h0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 32'h0;
    w_out_ready = 1'b0;
    fork
      monitor();
    join_none

    // 1: streaming fetch with 1-cycle memory; also the wrap instance
    budget = 8;
    out_ready = 1'b1;
    arm = 1'b1;
    push_seq(32'h0, 8);
    do_reset();
    @(negedge clock);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("wrap_rst_valid", 32'(w_req_valid), 32'd0);
    @(negedge clock);
    chk("wrap_first_valid", 32'(w_req_valid), 32'd1);
    chk("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
    @(negedge clock);
    chk("wrap_second_addr", w_req_addr, 32'h0);
    drain("t1_drain", 40);
    chk("t1_latency", 32'(first_out - first_acc), 32'd2);
    chk("t1_rate", 32'(last_out - first_out), 32'd7);
    for (int i = 0; i < 8; i++) chk("t1_addr", acc_log[i], 32'(4 * i));
    chk("wrap_out_valid", 32'(w_out_valid), 32'd0);
    chk("wrap_out_pc", w_out_pc, 32'h0);
    chk("wrap_out_instr", w_out_instr, 32'h0);
    arm = 1'b0;

    // 2: stalled consumer fills the queue, then drains and fetch resumes
    out_ready = 1'b0;
    budget = 8;
    do_reset();
    repeat (10) @(negedge clock);
    chk("t2_acc_cnt", 32'(acc_cnt), 32'd4);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t2_head_valid", 32'(out_valid), 32'd1);
    chk("t2_head_pc", out_pc, 32'h0);
    tick();
    push_seq(32'h0, 8);
    out_ready = 1'b1;
    drain("t2_drain", 40);
    chk("t2_resume_addr", acc_log[4], 32'h10);
    chk("t2_last_addr", acc_log[7], 32'h1C);

    // 3: redirect with three requests in flight
    hold = 1'b1;
    budget = 0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    budget = 3;
    repeat (6) tick();
    chk("t3_acc_cnt", 32'(acc_cnt), 32'd3);
    chk("t3_addr2", acc_log[2], 32'h28);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clock);
    chk("t3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    push_seq(32'h100, 2);
    budget = acc_cnt + 2;
    hold = 1'b0;
    @(negedge clock);
    chk("t3_drop_cnt", 32'(dut.drop_cnt), 32'd3);
    drain("t3_drain", 40);
    chk("t3_new_addr", acc_log[3], 32'h100);
    chk("t3_new_addr2", acc_log[4], 32'h104);

    // 4: redirect coincides with a response and a poppable head
    hold = 1'b1;
    budget = 3;
    do_reset();
    repeat (6) tick();
    hold = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    budget = acc_cnt + 2;
    push_seq(32'h200, 2);
    @(negedge clock);
    chk("t4_no_pop", 32'(out_valid), 32'd0);
    chk("t4_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("t4_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    drain("t4_drain", 40);
    chk("t4_new_addr", acc_log[3], 32'h200);

    // 6: reset with two filled and two pending entries
    out_ready = 1'b0;
    hold = 1'b0;
    budget = 2;
    do_reset();
    repeat (6) tick();
    hold = 1'b1;
    budget = acc_cnt + 2;
    repeat (5) tick();
    @(negedge clock);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_acc", 32'(acc_cnt), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_out_pc", out_pc, 32'h0);
    budget = 1;
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t6_acc_cnt", 32'(acc_cnt), 32'd1);
    chk("t6_first_addr", acc_log[0], 32'h0);

    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
